acp_burst_writer: RTL and testbench



---
 rtl/acp_burst_if.sv | 57 +++++
 rtl/acp_burst_writer.sv | 171 +++++++++++++++++
 tb/tb_acp_burst_writer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acp_burst_if.sv
// Command, write-stream and AXI4 write-channel bundle for the ACP burst writer.
// The master modport is the writer side; slave is the command/stream source plus the ACP slave.
`timescale 1ns/1ps
interface acp_burst_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) ();
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_beats;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [DATA_WIDTH-1:0]   s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [7:0]              M_AXI_AWLEN;
  logic [2:0]              M_AXI_AWSIZE;
  logic [1:0]              M_AXI_AWBURST;
  logic [2:0]              M_AXI_AWPROT;
  logic [3:0]              M_AXI_AWCACHE;
  logic [4:0]              M_AXI_AWUSER;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WLAST;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;

  modport master (
    input  cmd_addr, cmd_beats, cmd_valid, s_tdata, s_tvalid,
    output cmd_ready, s_tready,
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT,
    output M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output cmd_addr, cmd_beats, cmd_valid, s_tdata, s_tvalid,
    input  cmd_ready, s_tready,
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT,
    input  M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/acp_burst_writer.sv
// AXI4 INCR burst write master for the Zynq ACP: splits a command into bursts at
// MAX_BURST and 4 KB boundaries, one burst outstanding, with done/err/irq reporting.
`timescale 1ns/1ps
module acp_burst_writer #(
  parameter int         DATA_WIDTH = 64,
  parameter int         ADDR_WIDTH = 32,
  parameter int         LEN_WIDTH  = 16,
  parameter int         MAX_BURST  = 16,
  parameter logic [3:0] AXCACHE    = 4'b1111,
  parameter logic [4:0] AXUSER     = 5'b00001
) (
  input  logic         clk,
  input  logic         rst,
  acp_burst_if.master  bus,
  output logic         done,
  output logic         err,
  output logic         irq,
  input  logic         irq_clear
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [7:0]            beat_q, beat_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;
  logic                  w_fire, w_last;

  // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page end.
  function automatic logic [12:0] burst_len(input logic [11:0] a_lo,
                                            input logic [LEN_WIDTH-1:0] rem);
    logic [12:0] page;
    logic [12:0] n;
    page = (13'd4096 - {1'b0, a_lo}) >> SIZE;
    n = 13'(MAX_BURST);
    if (page < n) n = page;
    if (32'(rem) < 32'(n)) n = 13'(rem);
    return n;
  endfunction

  assign w_fire = (state_q == DATA) && bus.s_tvalid && bus.M_AXI_WREADY;
  assign w_last = (state_q == DATA) && (beat_q == awlen_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    awlen_d   = awlen_q;
    beat_d    = beat_q;
    awvalid_d = awvalid_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    err_d     = err_q;
    irq_d     = irq_q && !irq_clear;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
          rem_d   = bus.cmd_beats;
          err_d   = 1'b0;
          awlen_d = 8'(burst_len(addr_d[11:0], bus.cmd_beats) - 13'd1);
          if (bus.cmd_beats == '0) begin
            state_d = FIN;
          end else begin
            state_d   = ADDR;
            awvalid_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (bus.M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          beat_d    = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (w_fire) begin
          beat_d = beat_q + 8'd1;
          if (w_last) begin
            state_d  = RESP;
            bready_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (bus.M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (bus.M_AXI_BRESP != 2'b00) err_d = 1'b1;
          addr_d  = addr_q + ((ADDR_WIDTH'(awlen_q) + ADDR_WIDTH'(1)) << SIZE);
          rem_d   = rem_q - (LEN_WIDTH'(awlen_q) + LEN_WIDTH'(1));
          awlen_d = 8'(burst_len(addr_d[11:0], rem_d) - 13'd1);
          if (rem_d != '0) begin
            state_d   = ADDR;
            awvalid_d = 1'b1;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      FIN: begin
        // A zero-beat command arrives here without done and spends one extra cycle.
        if (done_q) begin
          state_d = IDLE;
          irq_d   = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      awvalid_q   <= awvalid_d;
      bready_q    <= bready_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWLEN   = awlen_q;
  assign bus.M_AXI_AWSIZE  = 3'(SIZE);
  assign bus.M_AXI_AWBURST = 2'b01;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWCACHE = AXCACHE;
  assign bus.M_AXI_AWUSER  = AXUSER;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = bus.s_tdata;
  assign bus.M_AXI_WSTRB   = '1;
  assign bus.M_AXI_WVALID  = (state_q == DATA) && bus.s_tvalid;
  assign bus.M_AXI_WLAST   = w_last;
  assign bus.s_tready      = (state_q == DATA) && bus.M_AXI_WREADY;
  assign bus.M_AXI_BREADY  = bready_q;
  assign done              = done_q;
  assign err               = err_q;
  assign irq               = irq_q;
endmodule

// File: tb/tb_acp_burst_writer.sv
// Directed bench for acp_burst_writer: a cycle-stepped ACP slave and stream source
// with AW/W scoreboards filled from the command and popped on each handshake.
`timescale 1ns/1ps
module tb_acp_burst_writer;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst;
  logic irq_clear;
  logic done, err, irq;

  acp_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  acp_burst_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_BURST(MB),
    .AXCACHE(4'b1111), .AXUSER(5'b00001)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .done(done), .err(err), .irq(irq), .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_w[$];
  logic [AW-1:0] exp_aw_addr[$];
  logic [7:0]    exp_aw_len[$];
  logic [AW-1:0] aw_log[$];
  logic [7:0]    awlen_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rb(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid     = 1'b0;
    bus.s_tvalid      = 1'b0;
    bus.s_tdata       = '0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    irq_clear         = 1'b0;
  endtask

  // Runs one command; abort_after>0 returns right after that many W beats handshake.
  task automatic run_cmd(input logic [AW-1:0] addr, input int beats, input int pct,
                         input int err_burst, input int abort_after, input bit race);
    logic [DW-1:0] stream[];
    logic [AW-1:0] a, sv_addr;
    logic [7:0]    sv_len, cur_len;
    int rem, n, page, nbursts, sidx, wcount, win, bidx, cyc;
    bit b_pend, exp_done, first, aw_wait, fin, exp_err;

    exp_w.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
    aw_log.delete(); awlen_log.delete();
    a = addr & ~32'h7; rem = beats; nbursts = 0;
    while (rem > 0) begin
      page = (4096 - int'(a[11:0])) / 8;
      n = rem;
      if (n > MB) n = MB;
      if (n > page) n = page;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(8'(n - 1));
      a += 32'(n * 8);
      rem -= n;
      nbursts++;
    end
    stream = new[beats];
    for (int i = 0; i < beats; i++) begin
      stream[i] = {$urandom, $urandom};
      exp_w.push_back(stream[i]);
    end
    exp_err = (err_burst >= 0) && (err_burst < nbursts);

    @(negedge clk);
    bus.cmd_addr  = addr;
    bus.cmd_beats = LW'(beats);
    bus.cmd_valid = 1'b1;
    #1 chk("cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;

    sidx = 0; wcount = 0; win = 0; bidx = 0; cyc = 0; cur_len = 0;
    sv_addr = '0; sv_len = '0;
    b_pend = 0; exp_done = 0; first = 1; aw_wait = 0; fin = 0;
    while (!fin) begin
      if (!first) @(negedge clk);
      bus.M_AXI_AWREADY = rb(pct);
      bus.M_AXI_WREADY  = rb(pct);
      bus.s_tvalid      = (sidx < beats) && rb(pct);
      bus.s_tdata       = (sidx < beats) ? stream[sidx] : '0;
      bus.M_AXI_BVALID  = b_pend && rb(pct);
      bus.M_AXI_BRESP   = (bidx == err_burst) ? 2'b10 : 2'b00;
      irq_clear         = race && exp_done;
      #1;
      if (first) begin
        chk("awvalid_after_cmd", bus.M_AXI_AWVALID, beats != 0);
        if (beats == 0) chk("zero_done_early", done, 0);
        first = 0;
      end
      if (exp_done || done) begin
        chk("done_timing", done, exp_done);
        chk("err_at_done", err, exp_err);
        fin = 1;
      end
      if (bus.M_AXI_AWVALID) begin
        if (aw_wait) begin
          chk("aw_stable_addr", bus.M_AXI_AWADDR, sv_addr);
          chk("aw_stable_len", bus.M_AXI_AWLEN, sv_len);
        end
        if (bus.M_AXI_AWREADY) begin
          aw_log.push_back(bus.M_AXI_AWADDR);
          awlen_log.push_back(bus.M_AXI_AWLEN);
          if (exp_aw_addr.size() == 0) begin
            chk("aw_extra", 1, 0);
          end else begin
            chk("awaddr", bus.M_AXI_AWADDR, exp_aw_addr.pop_front());
            cur_len = exp_aw_len.pop_front();
            chk("awlen", bus.M_AXI_AWLEN, cur_len);
            chk("aw_consts", {bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST, bus.M_AXI_AWPROT,
                              bus.M_AXI_AWCACHE, bus.M_AXI_AWUSER},
                {3'd3, 2'b01, 3'b000, 4'b1111, 5'b00001});
          end
          win = 0;
          aw_wait = 0;
        end else begin
          aw_wait = 1;
          sv_addr = bus.M_AXI_AWADDR;
          sv_len  = bus.M_AXI_AWLEN;
        end
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        if (exp_w.size() == 0) chk("w_extra", 1, 0);
        else chk("wdata", bus.M_AXI_WDATA, exp_w.pop_front());
        chk("wlast", bus.M_AXI_WLAST, win == int'(cur_len));
        chk("wstrb", bus.M_AXI_WSTRB, 8'hFF);
        if (bus.M_AXI_WLAST) b_pend = 1;
        win++;
        wcount++;
      end
      if (bus.s_tvalid && bus.s_tready) sidx++;
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        b_pend = 0;
        bidx++;
        if (bidx == nbursts) exp_done = 1;
      end
      if (beats == 0 && cyc == 0) exp_done = 1;
      if (abort_after > 0 && wcount == abort_after) break;
      cyc++;
      if (cyc > 20000) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
    end
    if (abort_after > 0) return;

    chk("w_count", wcount, beats);
    chk("aw_left", exp_aw_addr.size(), 0);
    idle_inputs();
    irq_clear = race;
    @(negedge clk);
    #1;
    chk("irq_set", irq, 1);
    chk("done_pulse_one", done, 0);
    if (race) begin
      @(negedge clk);
      irq_clear = 1'b0;
      #1 chk("irq_cleared", irq, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_addr  = '0;
    bus.cmd_beats = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    bus.s_tvalid     = 1'b1;
    bus.M_AXI_WREADY = 1'b1;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
    chk("rst_wvalid", bus.M_AXI_WVALID, 0);
    chk("rst_wlast", bus.M_AXI_WLAST, 0);
    chk("rst_bready", bus.M_AXI_BREADY, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_done_err_irq", {done, err, irq}, 3'b000);
    chk("rst_aw_payload", {bus.M_AXI_AWADDR, bus.M_AXI_AWLEN}, 40'h0);
    rst = 1'b0;
    idle_inputs();

    // Single aligned burst
    run_cmd(32'h1000_0000, 16, 100, -1, 0, 0);
    chk("single_aw_count", aw_log.size(), 1);
    if (aw_log.size() == 1) begin
      chk("single_awaddr", aw_log[0], 32'h1000_0000);
      chk("single_awlen", awlen_log[0], 15);
    end

    // 4 KB split
    run_cmd(32'h0000_0FC0, 20, 100, -1, 0, 0);
    chk("split_aw_count", aw_log.size(), 2);
    if (aw_log.size() == 2) begin
      chk("split_awaddr0", aw_log[0], 32'h0000_0FC0);
      chk("split_awlen0", awlen_log[0], 7);
      chk("split_awaddr1", aw_log[1], 32'h0000_1000);
      chk("split_awlen1", awlen_log[1], 11);
    end

    // Random backpressure on every channel
    run_cmd(32'h2000_0000, 1000, 55, -1, 0, 0);
    chk("bp_aw_count", aw_log.size(), 63);

    // SLVERR on the middle burst does not abort
    run_cmd(32'h4000_0000, 48, 100, 1, 0, 0);
    chk("err_aw_count", aw_log.size(), 3);

    // Zero-beat command
    run_cmd(32'h4000_1000, 0, 100, -1, 0, 0);
    chk("zero_aw_count", aw_log.size(), 0);

    // Reset in the middle of a data phase
    run_cmd(32'h3000_0000, 16, 100, -1, 5, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_wvalid", bus.M_AXI_WVALID, 0);
    chk("midrst_awvalid", bus.M_AXI_AWVALID, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    chk("midrst_irq", irq, 0);
    rst = 1'b0;
    idle_inputs();
    run_cmd(32'h3000_1000, 16, 100, -1, 0, 0);
    chk("post_rst_aw_count", aw_log.size(), 1);

    // irq set and clear in the same cycle
    run_cmd(32'h5000_0000, 8, 100, -1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
